// File: rtl/rv523_cell_pkg.sv
// Shared definitions for RV523 4-input cell self-test: truth tables, input-bit
// mapping and the sequencer state encoding.
package rv523_cell_pkg;

  // Bit i of each table is the expected Y for vector index i.
  localparam logic [15:0] TT_AOI22 = 16'h0777;
  localparam logic [15:0] TT_OAI22 = 16'h111F;
  localparam logic [15:0] TT_AND4  = 16'h8000;
  localparam logic [15:0] TT_NAND4 = 16'h7FFF;

  // Position of each cell input inside the 4-bit vector index.
  localparam int VB_A1 = 0;
  localparam int VB_A2 = 1;
  localparam int VB_B1 = 2;
  localparam int VB_B2 = 3;

  localparam logic [3:0] LAST_VEC = 4'd15;

  // The finish step is folded into the SAMPLE exit edge, so the done cycle is
  // already IDLE and can accept the next start.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } bist_state_t;

  function automatic logic tt_expect(input logic [15:0] tt, input logic [3:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/rv523_settle_counter.sv
// Loadable down-counter that flags the last settle cycle of a vector.
module rv523_settle_counter #(
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_term
);

  localparam int W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(LOAD_VAL);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_term = (r_cnt == W'(1));

endmodule

// File: rtl/cell4_bist.sv
// Self-test sequencer: walks a 4-input cell through all 16 input vectors and
// scores each sampled Y against a parameterised truth table.
module cell4_bist
  import rv523_cell_pkg::*;
#(
  parameter logic [15:0] EXPECT        = TT_AOI22,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       drv_a1,
  output logic       drv_a2,
  output logic       drv_b1,
  output logic       drv_b2,
  input  logic       dut_y,
  output logic [4:0] fail_count,
  output logic [3:0] fail_vec
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("cell4_bist: SETTLE_CYCLES must be at least 1");
  end

  bist_state_t r_state;
  logic [3:0]  r_vec;
  logic [3:0]  r_drv;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_fail_count;
  logic [3:0]  r_fail_vec;

  logic       w_mismatch;
  logic       w_stop;
  logic       w_load;
  logic       w_dec;
  logic       w_term;
  logic [4:0] w_fail_next;
  logic [3:0] w_vec_next;

  assign w_mismatch  = (dut_y != tt_expect(EXPECT, r_vec));
  assign w_stop      = (r_vec == LAST_VEC) || (STOP_ON_FAIL && w_mismatch);
  assign w_fail_next = r_fail_count + {4'd0, w_mismatch};
  assign w_vec_next  = r_vec + 4'd1;
  assign w_dec       = (r_state == ST_SETTLE);
  assign w_load      = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_SAMPLE) && !w_stop);

  rv523_settle_counter #(
    .LOAD_VAL (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_term (w_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vec        <= '0;
      r_drv        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_fail_vec   <= '0;
    end else begin
      // NOTE: default-low here makes done a single-cycle pulse without extra state.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_drv <= '0;
          if (start) begin
            r_vec        <= '0;
            r_fail_count <= '0;
            r_fail_vec   <= '0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_term) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            r_fail_count <= w_fail_next;
            if (r_fail_count == '0) r_fail_vec <= r_vec;
          end
          if (w_stop) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_fail_next == '0);
            r_drv   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_vec   <= w_vec_next;
            r_drv   <= w_vec_next;
            r_state <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign drv_a1     = r_drv[VB_A1];
  assign drv_a2     = r_drv[VB_A2];
  assign drv_b1     = r_drv[VB_B1];
  assign drv_b2     = r_drv[VB_B2];
  assign fail_count = r_fail_count;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_cell4_bist.sv
// Scoreboard bench for cell4_bist: stimulus pushes expected run results, monitors
// pop and compare on every done pulse; drive sequence is checked every cycle.
module tb_cell4_bist;
  import rv523_cell_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic y0, y1;

  logic       busy0, done0, pass0, a1_0, a2_0, b1_0, b2_0;
  logic [4:0] fc0;
  logic [3:0] fv0;
  logic       busy1, done1, pass1, a1_1, a2_1, b1_1, b2_1;
  logic [4:0] fc1;
  logic [3:0] fv1;

  always #5 clk = ~clk;

  cell4_bist u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .drv_a1(a1_0), .drv_a2(a2_0), .drv_b1(b1_0), .drv_b2(b2_0), .dut_y(y0),
    .fail_count(fc0), .fail_vec(fv0)
  );

  cell4_bist #(.STOP_ON_FAIL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .drv_a1(a1_1), .drv_a2(a2_1), .drv_b1(b1_1), .drv_b2(b2_1), .dut_y(y1),
    .fail_count(fc1), .fail_vec(fv1)
  );

  typedef struct {
    int fc;
    int fv;
    int pass;
    int done_cyc;
    int busy_len;
  } exp_t;

  typedef enum {M_GOLD, M_ST1, M_ST0, M_GLITCH} ymode_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     seq_cyc = 0;
  int     blen0 = 0;
  int     blen1 = 0;
  int     done_seen = 0;
  ymode_t mode0 = M_GOLD;
  logic   golden;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Cycles since the accept edge of the current dut0 run.
  always @(posedge clk) begin
    if (!busy0 && start0 && !rst) seq_cyc <= 0;
    else seq_cyc <= seq_cyc + 1;
  end

  // Cell model for dut0: AOI22, optionally faulted or glitching in the first settle cycle.
  assign golden = ~((a1_0 & a2_0) | (b1_0 & b2_0));
  always_comb begin
    y0 = golden;
    case (mode0)
      M_ST1:    y0 = 1'b1;
      M_ST0:    y0 = 1'b0;
      M_GLITCH: y0 = (busy0 && (seq_cyc % 3 == 0)) ? ~golden : golden;
      default:  y0 = golden;
    endcase
  end

  // Drive-sequence monitor: each vector held 3 cycles while busy, all zero otherwise.
  always @(negedge clk) begin
    if (busy0) check("drv_seq", {b2_0, b1_0, a2_0, a1_0}, seq_cyc / 3);
    else       check("drv_idle", {b2_0, b1_0, a2_0, a1_0}, 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      blen0 = 0;
    end else begin
      if (busy0) blen0++;
      if (done0) begin
        done_seen++;
        if (q0.size() == 0) begin
          check("unexpected_done0", 1, 0);
        end else begin
          e = q0.pop_front();
          check("fail_count0", fc0, e.fc);
          if (e.fc != 0) check("fail_vec0", fv0, e.fv);
          check("pass0", pass0, e.pass);
          check("done_cycle0", cyc, e.done_cyc);
          check("busy_len0", blen0, e.busy_len);
          check("busy_in_done0", busy0, 0);
        end
        blen0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      blen1 = 0;
    end else begin
      if (busy1) blen1++;
      if (done1) begin
        if (q1.size() == 0) begin
          check("unexpected_done1", 1, 0);
        end else begin
          e = q1.pop_front();
          check("fail_count1", fc1, e.fc);
          check("fail_vec1", fv1, e.fv);
          check("pass1", pass1, e.pass);
          check("done_cycle1", cyc, e.done_cyc);
          check("busy_len1", blen1, e.busy_len);
          check("drv_zero1", {b2_1, b1_1, a2_1, a1_1}, 0);
        end
        blen1 = 0;
      end
    end
  end

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check("timeout_pending", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic run0(input ymode_t m, input int fc, input int fv, input int p);
    @(negedge clk);
    mode0  = m;
    start0 = 1'b1;
    q0.push_back('{fc: fc, fv: fv, pass: p, done_cyc: cyc + 49, busy_len: 48});
    @(negedge clk);
    start0 = 1'b0;
    drain(200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; y1 = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_fail_count", fc0, 0);
    check("rst_fail_vec", fv0, 0);
    check("rst_busy1", busy1, 0);
    #1 rst = 1'b0;

    // 1: golden AOI22, with a stray start pulse mid-run that must be ignored.
    @(negedge clk);
    mode0 = M_GOLD;
    start0 = 1'b1;
    q0.push_back('{fc: 0, fv: 0, pass: 1, done_cyc: cyc + 49, busy_len: 48});
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain(200);
    repeat (3) @(negedge clk);
    check("pass_hold", pass0, 1);

    // 2: Y stuck-at-1 fails vectors 3,7,11,12,13,14,15.
    run0(M_ST1, 7, 3, 0);
    check("pass_hold_fail", pass0, 0);

    // 3: stop-on-fail instance with Y stuck-at-0 fails vector 0 and ends early.
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back('{fc: 1, fv: 0, pass: 0, done_cyc: cyc + 4, busy_len: 3});
    @(negedge clk);
    start1 = 1'b0;
    drain(50);

    // 4: wrong-value glitch in the first settle cycle of every vector is ignored.
    run0(M_GLITCH, 0, 0, 1);

    // 5: reset during vector 6 aborts with no done pulse.
    @(negedge clk);
    mode0 = M_ST1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_vec", {b2_0, b1_0, a2_0, a1_0}, 6);
    check("mid_fail_count", fc0, 1);
    check("mid_fail_vec", fv0, 3);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_drv", {b2_0, b1_0, a2_0, a1_0}, 0);
    check("abort_fail_count", fc0, 0);
    check("abort_fail_vec", fv0, 0);
    check("abort_done", done0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    done_seen = 0;
    repeat (60) @(negedge clk);
    check("abort_no_done", done_seen, 0);
    run0(M_GOLD, 0, 0, 1);

    // 6: start held high gives back-to-back runs every 49 cycles.
    @(negedge clk);
    mode0 = M_GOLD;
    start0 = 1'b1;
    for (int k = 0; k < 3; k++)
      q0.push_back('{fc: 0, fv: 0, pass: 1, done_cyc: cyc + 49 + 49 * k, busy_len: 48});
    repeat (147) @(negedge clk);
    start0 = 1'b0;
    drain(100);
    repeat (5) @(negedge clk);
    check("idle_after_held", busy0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cell4_bist.md
Name: cell4_bist

Overview:
- Self-test sequencer for 4-input, 1-output library cells built from RV523_NMOS/RV523_PMOS (AOI22, OAI22 and similar).
- It is the other end of the cell interface: it drives the cell's four inputs through all 16 combinations and reads back Y.
- Each sampled Y is compared against a parameterised truth table, and the block records pass/fail, the mismatch count and the first failing vector.
- Used in cell-library regression and in board bring-up of hand-built gates.

Parameters:
- EXPECT, 16'h0777, expected Y per vector index; bit i = Y for vec=i. The default is the AOI22 table.
- SETTLE_CYCLES, 2, cycles each vector is held before Y is sampled. Must be ≥1; 0 is an elaboration error.
- STOP_ON_FAIL, 0, when 1 the run ends at the first mismatch.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a run; accepted only in IDLE
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  1 = last run had no mismatches; held until the next accepted start or rst
- drv_a1  out  1  cell input A1 = vec[0]
- drv_a2  out  1  cell input A2 = vec[1]
- drv_b1  out  1  cell input B1 = vec[2]
- drv_b2  out  1  cell input B2 = vec[3]
- dut_y  in  1  cell output Y
- fail_count  out  5  mismatches in the last run, range 0..16
- fail_vec  out  4  first failing vector index; valid only when fail_count≠0

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, pass, drv_*, fail_count and fail_vec all 0; vec=0; settle counter=0.
- FSM states:
  - IDLE: drv_*=0. If start=1: vec←0, cnt←SETTLE_CYCLES, fail_count←0, fail_vec←0, pass←0, busy←1, go to SETTLE.
  - SETTLE: drv_* = vec bits. cnt decrements each cycle. On the cycle where cnt==1, go to SAMPLE. dut_y is ignored in this state (glitches allowed).
  - SAMPLE: compare dut_y against EXPECT[vec].
    - On mismatch: fail_count+1; fail_vec←vec if this is the first mismatch.
    - If vec==15, or (STOP_ON_FAIL and mismatch): go to FINISH.
    - Else: vec←vec+1, cnt←SETTLE_CYCLES, go to SETTLE.
  - FINISH: single cycle. busy←0, done←1, pass←(final fail_count==0), drv_*←0, go to IDLE.
- Timing: done is high for exactly one cycle, the first cycle busy is low. All outputs are registered.
- Latency, start-accept edge to done: 16×(SETTLE_CYCLES+1) cycles for a full run, which is 48 for the default.
- Per-vector hold: SETTLE_CYCLES+1 cycles, with dut_y sampled in the last of them.
- start while busy, in SETTLE, SAMPLE or FINISH: ignored, with no effect on the run.
- start high in the done cycle (IDLE): accepted, so back-to-back period is full latency + 1.
- vec never wraps: the run always terminates at vec=15.
- fail_count cannot overflow: 5 bits hold 16.
- rst mid-run: abort immediately to reset values; no done pulse.
- dut_y is assumed synchronous to clk (simulation netlist). Board use adds an external synchronizer, and SETTLE_CYCLES is increased to cover its delay.

Decomposition:
- Package rv523_cell_pkg holds:
  - truth-table constants: TT_AOI22=16'h0777, TT_OAI22=16'h111F, TT_AND4=16'h8000, TT_NAND4=16'h7FFF;
  - the vector-bit mapping (A1=0, A2=1, B1=2, B2=3);
  - the FSM state enum.
- One natural sub-module, rv523_settle_counter: a loadable down-counter with a terminal flag.

Test Plan:
1. Golden AOI22 netlist, defaults, single start pulse -> busy for 48 cycles, done pulse, pass=1, fail_count=0.
2. dut_y stuck-at-1 -> mismatches at vec 3, 7, 11, 12, 13, 14, 15; fail_count=7, fail_vec=3, pass=0.
3. STOP_ON_FAIL=1, dut_y stuck-at-0 -> done 3 cycles after start, fail_count=1, fail_vec=0, drv_* returned to 0.
4. Drive-sequence check -> drv_* steps 0..15, each held 3 cycles. A 1-cycle wrong-value glitch on dut_y in the first settle cycle of every vector -> pass=1.
5. Assert rst during vec=6 -> all outputs 0 within the same cycle, no done pulse; the next start gives a full 48-cycle run and pass=1.
6. start held high continuously -> done every 49 cycles and pass=1 each run; start pulses mid-run do not restart or extend the run.
